// File: rtl/sd_dat_block_rx.sv
// SD-card DAT-line block receiver: start-bit search with timeout, byte assembly,
// per-lane CRC16-CCITT and end-bit checking for single- and multi-block reads.
module sd_dat_block_rx #(
    parameter int BUS_WIDTH   = 4,
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT     = 1000000,
    parameter int TAIL_CLKS   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sdclk_rise,
    input  logic [3:0]                     sddat,
    input  logic                           start,
    input  logic [15:0]                    nblocks,
    input  logic                           abort,
    output logic                           busy,
    output logic                           outvalid,
    output logic [7:0]                     outbyte,
    output logic [$clog2(BLOCK_BYTES)-1:0] outaddr,
    output logic [15:0]                    outblk,
    output logic                           blk_done,
    output logic                           blk_crc_ok,
    output logic                           done,
    output logic                           err_timeout,
    output logic                           err_crc
);
    localparam int ADDR_W = $clog2(BLOCK_BYTES);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TAIL_W = (TAIL_CLKS > 1) ? $clog2(TAIL_CLKS) : 1;
    localparam int SH_W   = 8 - BUS_WIDTH;
    localparam logic [2:0] SUB_LAST = 3'(8 / BUS_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, ENDBIT, TAIL} state_t;

    state_t                     state_reg, state_next;
    logic [15:0]                nblk_reg, nblk_next;
    logic [WAIT_W-1:0]          wait_reg, wait_next;
    logic [SH_W-1:0]            shift_reg, shift_next;
    logic [2:0]                 sub_reg, sub_next;
    logic [ADDR_W-1:0]          byte_reg, byte_next;
    logic [3:0]                 bit_reg, bit_next;
    logic [TAIL_W-1:0]          tail_reg, tail_next;
    logic                       ok_reg, ok_next;
    logic [BUS_WIDTH-1:0][15:0] crc_reg, crc_next, crc_fed, crc_shl;

    logic                       busy_next, outvalid_next, blk_done_next, blk_crc_ok_next;
    logic                       done_next, err_timeout_next, err_crc_next;
    logic [7:0]                 outbyte_next;
    logic [ADDR_W-1:0]          outaddr_next;
    logic [15:0]                outblk_next;

    logic [BUS_WIDTH-1:0]       lanes;
    logic [BUS_WIDTH-1:0]       lane_crc_bad;
    logic [7:0]                 byte_asm;
    logic                       block_ok;
    logic                       unused_lanes;

    assign lanes        = sddat[BUS_WIDTH-1:0];
    assign unused_lanes = &{1'b0, sddat};
    // Data arrives MSB first, so new lane bits always enter at the bottom.
    assign byte_asm     = {shift_reg, lanes};
    assign block_ok     = ok_reg & (&lanes);

    genvar gi;
    generate
        for (gi = 0; gi < BUS_WIDTH; gi++) begin : g_lane
            assign crc_fed[gi] = {crc_reg[gi][14:0], 1'b0}
                               ^ (((crc_reg[gi][15] ^ lanes[gi]) == 1'b1) ? 16'h1021 : 16'h0000);
            // During the CRC phase the computed value is shifted out MSB first and compared.
            assign crc_shl[gi]      = {crc_reg[gi][14:0], 1'b0};
            assign lane_crc_bad[gi] = crc_reg[gi][15] ^ lanes[gi];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        nblk_next        = nblk_reg;
        wait_next        = wait_reg;
        shift_next       = shift_reg;
        sub_next         = sub_reg;
        byte_next        = byte_reg;
        bit_next         = bit_reg;
        tail_next        = tail_reg;
        ok_next          = ok_reg;
        crc_next         = crc_reg;
        outvalid_next    = 1'b0;
        outbyte_next     = outbyte;
        outaddr_next     = outaddr;
        outblk_next      = outblk;
        blk_done_next    = 1'b0;
        blk_crc_ok_next  = 1'b0;
        done_next        = 1'b0;
        err_timeout_next = err_timeout;
        err_crc_next     = err_crc;

        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        nblk_next        = (nblocks == 16'd0) ? 16'd1 : nblocks;
                        err_timeout_next = 1'b0;
                        err_crc_next     = 1'b0;
                        outblk_next      = 16'd0;
                        wait_next        = '0;
                        state_next       = WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (sdclk_rise) begin
                        if (~|lanes) begin
                            crc_next   = '0;
                            shift_next = '0;
                            sub_next   = 3'd0;
                            byte_next  = '0;
                            ok_next    = 1'b1;
                            state_next = DATA;
                        end else if (wait_reg == WAIT_W'(TIMEOUT)) begin
                            err_timeout_next = 1'b1;
                            done_next        = 1'b1;
                            state_next       = IDLE;
                        end else begin
                            wait_next = wait_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sdclk_rise) begin
                        crc_next   = crc_fed;
                        shift_next = byte_asm[SH_W-1:0];
                        if (sub_reg == SUB_LAST) begin
                            sub_next      = 3'd0;
                            outvalid_next = 1'b1;
                            outbyte_next  = byte_asm;
                            outaddr_next  = byte_reg;
                            byte_next     = byte_reg + 1'b1;
                            if (byte_reg == ADDR_W'(BLOCK_BYTES - 1)) begin
                                bit_next   = 4'd0;
                                state_next = CRC;
                            end
                        end else begin
                            sub_next = sub_reg + 1'b1;
                        end
                    end
                end
                CRC: begin
                    if (sdclk_rise) begin
                        crc_next = crc_shl;
                        if (|lane_crc_bad) begin
                            ok_next = 1'b0;
                        end
                        bit_next = bit_reg + 1'b1;
                        if (bit_reg == 4'd15) begin
                            state_next = ENDBIT;
                        end
                    end
                end
                ENDBIT: begin
                    if (sdclk_rise) begin
                        blk_done_next   = 1'b1;
                        blk_crc_ok_next = block_ok;
                        if (!block_ok) begin
                            err_crc_next = 1'b1;
                        end
                        if (outblk == nblk_reg - 16'd1) begin
                            if (TAIL_CLKS == 0) begin
                                done_next  = 1'b1;
                                state_next = IDLE;
                            end else begin
                                tail_next  = '0;
                                state_next = TAIL;
                            end
                        end else begin
                            outblk_next = outblk + 16'd1;
                            wait_next   = '0;
                            state_next  = WAIT_START;
                        end
                    end
                end
                TAIL: begin
                    if (sdclk_rise) begin
                        if (tail_reg == TAIL_W'(TAIL_CLKS - 1)) begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            tail_next = tail_reg + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            nblk_reg    <= 16'd0;
            wait_reg    <= '0;
            shift_reg   <= '0;
            sub_reg     <= 3'd0;
            byte_reg    <= '0;
            bit_reg     <= 4'd0;
            tail_reg    <= '0;
            ok_reg      <= 1'b0;
            crc_reg     <= '0;
            busy        <= 1'b0;
            outvalid    <= 1'b0;
            outbyte     <= 8'd0;
            outaddr     <= '0;
            outblk      <= 16'd0;
            blk_done    <= 1'b0;
            blk_crc_ok  <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_crc     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            nblk_reg    <= nblk_next;
            wait_reg    <= wait_next;
            shift_reg   <= shift_next;
            sub_reg     <= sub_next;
            byte_reg    <= byte_next;
            bit_reg     <= bit_next;
            tail_reg    <= tail_next;
            ok_reg      <= ok_next;
            crc_reg     <= crc_next;
            busy        <= busy_next;
            outvalid    <= outvalid_next;
            outbyte     <= outbyte_next;
            outaddr     <= outaddr_next;
            outblk      <= outblk_next;
            blk_done    <= blk_done_next;
            blk_crc_ok  <= blk_crc_ok_next;
            done        <= done_next;
            err_timeout <= err_timeout_next;
            err_crc     <= err_crc_next;
        end
    end

endmodule

// File: tb/tb_sd_dat_block_rx.sv
// Directed bench for sd_dat_block_rx: one 4-bit and one 1-bit instance with small blocks,
// driven by hand-built DAT streams with bench-computed CRCs.
`timescale 1ns/1ps
module tb_sd_dat_block_rx;
    localparam int BB = 16;
    localparam int TO = 200;
    localparam int TC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdclk_rise;
    logic [3:0]  sddat;
    logic        start4, start1;
    logic [15:0] nblocks;
    logic        abort;

    logic        busy4, valid4, bdone4, bok4, done4, eto4, ecrc4;
    logic [7:0]  byte4;
    logic [3:0]  addr4;
    logic [15:0] blk4;
    logic        busy1, valid1, bdone1, bok1, done1, eto1, ecrc1;
    logic [7:0]  byte1;
    logic [3:0]  addr1;
    logic [15:0] blk1;

    sd_dat_block_rx #(.BUS_WIDTH(4), .BLOCK_BYTES(BB), .TIMEOUT(TO), .TAIL_CLKS(TC)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .sdclk_rise(sdclk_rise), .sddat(sddat), .start(start4),
        .nblocks(nblocks), .abort(abort), .busy(busy4), .outvalid(valid4), .outbyte(byte4),
        .outaddr(addr4), .outblk(blk4), .blk_done(bdone4), .blk_crc_ok(bok4), .done(done4),
        .err_timeout(eto4), .err_crc(ecrc4)
    );

    sd_dat_block_rx #(.BUS_WIDTH(1), .BLOCK_BYTES(BB), .TIMEOUT(TO), .TAIL_CLKS(TC)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sdclk_rise(sdclk_rise), .sddat(sddat), .start(start1),
        .nblocks(nblocks), .abort(abort), .busy(busy1), .outvalid(valid1), .outbyte(byte1),
        .outaddr(addr1), .outblk(blk1), .blk_done(bdone1), .blk_crc_ok(bok1), .done(done1),
        .err_timeout(eto1), .err_crc(ecrc1)
    );

    always #5 clk = ~clk;

    bit   w1 = 1'b0;
    int   gap = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic s_busy, s_valid, s_bdone, s_bok, s_done, s_eto, s_ecrc;
    logic [7:0] s_byte;

    assign s_busy  = w1 ? busy1  : busy4;
    assign s_valid = w1 ? valid1 : valid4;
    assign s_bdone = w1 ? bdone1 : bdone4;
    assign s_bok   = w1 ? bok1   : bok4;
    assign s_done  = w1 ? done1  : done4;
    assign s_eto   = w1 ? eto1   : eto4;
    assign s_ecrc  = w1 ? ecrc1  : ecrc4;
    assign s_byte  = w1 ? byte1  : byte4;

    logic [7:0] q_byte[$];
    int         q_addr[$];
    int         q_blk[$];
    logic       q_ok[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (s_valid) begin
            q_byte.push_back(s_byte);
            q_addr.push_back(int'(w1 ? addr1 : addr4));
            q_blk.push_back(int'(w1 ? blk1 : blk4));
        end
        if (s_bdone) q_ok.push_back(s_bok);
        if (s_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = {c[14:0], 1'b0};
        if (c[15] ^ b) r = r ^ 16'h1021;
        return r;
    endfunction

    function automatic logic [7:0] dbyte(input bit one, input int blk, input int i);
        if (one) return 8'(i);
        return 8'(i * 37 + blk * 91 + 5);
    endfunction

    task automatic clear_mon();
        q_byte.delete(); q_addr.delete(); q_blk.delete(); q_ok.delete();
        done_cnt = 0;
    endtask

    // Optional idle gap cycles carry inverted data so only strobed samples matter.
    task automatic strobe(input logic [3:0] d);
        for (int g = 0; g < gap; g++) begin
            sdclk_rise = 1'b0; sddat = ~d;
            @(posedge clk); #1;
        end
        sddat = d; sdclk_rise = 1'b1;
        @(posedge clk); #1;
        sdclk_rise = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] nb);
        nblocks = nb; sdclk_rise = 1'b0;
        if (w1) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
    endtask

    task automatic send_block(input int blk, input int flip_lane, input int nbytes);
        logic [15:0] crc [4];
        logic [7:0]  b;
        logic [3:0]  d;
        for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
        strobe(4'hF); strobe(4'hF);
        strobe(w1 ? 4'b1110 : 4'b0000);
        for (int i = 0; i < nbytes; i++) begin
            b = dbyte(w1, blk, i);
            if (w1) begin
                for (int k = 7; k >= 0; k--) begin
                    strobe({3'b010, b[k]});
                    crc[0] = crc_upd(crc[0], b[k]);
                end
            end else begin
                d = b[7:4]; strobe(d);
                for (int l = 0; l < 4; l++) crc[l] = crc_upd(crc[l], d[l]);
                d = b[3:0]; strobe(d);
                for (int l = 0; l < 4; l++) crc[l] = crc_upd(crc[l], d[l]);
            end
            if (i == 0) begin
                check($sformatf("b%0d_first_valid", blk), 32'(s_valid), 32'd1);
                check($sformatf("b%0d_first_byte", blk), 32'(s_byte), 32'(b));
            end
        end
        if (nbytes < BB) return;
        for (int k = 15; k >= 0; k--) begin
            for (int l = 0; l < 4; l++) d[l] = crc[l][k];
            if (flip_lane >= 0 && k == 9) d[flip_lane] = ~d[flip_lane];
            if (w1) d[3:1] = 3'b101;
            strobe(d);
        end
        strobe(w1 ? 4'b0101 : 4'b1111);
        check($sformatf("b%0d_blk_done", blk), 32'(s_bdone), 32'd1);
    endtask

    task automatic tail_check(input string tag, input int n);
        int early = 0;
        for (int k = 0; k < n - 1; k++) begin
            strobe(4'hF);
            if (s_done) early++;
        end
        check({tag, "_done_early"}, 32'(early), 32'd0);
        strobe(4'hF);
        check({tag, "_done"}, 32'(s_done), 32'd1);
        check({tag, "_busy_low"}, 32'(s_busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_1clk"}, 32'(s_done), 32'd0);
    endtask

    task automatic check_stream(input string tag, input int nbytes);
        int blk, i;
        check({tag, "_byte_count"}, 32'(q_byte.size()), 32'(nbytes));
        for (int k = 0; k < q_byte.size() && k < nbytes; k++) begin
            blk = k / BB; i = k % BB;
            check($sformatf("%s_val[%0d]", tag, k), 32'(q_byte[k]), 32'(dbyte(w1, blk, i)));
            check($sformatf("%s_addr[%0d]", tag, k), 32'(q_addr[k]), 32'(i));
            check($sformatf("%s_blk[%0d]", tag, k), 32'(q_blk[k]), 32'(blk));
        end
    endtask

    initial begin
        int early;
        rst_n = 1'b0; sdclk_rise = 1'b0; sddat = 4'hF;
        start4 = 1'b0; start1 = 1'b0; nblocks = 16'd1; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy4 | busy1), 32'd0);
        check("rst_valid", 32'(valid4 | valid1), 32'd0);
        check("rst_done", 32'(done4 | done1), 32'd0);
        check("rst_errs", 32'({eto4, ecrc4, eto1, ecrc1}), 32'd0);
        check("rst_blk_addr", 32'({blk4, addr4}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1-bit single block, bytes i, strobes every other clk
        w1 = 1'b1; gap = 1; clear_mon();
        do_start(16'd1);
        check("t1_busy", 32'(s_busy), 32'd1);
        send_block(0, -1, BB);
        check("t1_crc_ok", 32'(s_bok), 32'd1);
        tail_check("t1", TC);
        check_stream("t1", BB);
        check("t1_ok_count", 32'(q_ok.size()), 32'd1);
        check("t1_done_count", 32'(done_cnt), 32'd1);
        check("t1_err_crc", 32'(s_ecrc), 32'd0);

        // 4-bit, three blocks, back-to-back strobes
        w1 = 1'b0; gap = 0; clear_mon();
        do_start(16'd3);
        for (int b = 0; b < 3; b++) begin
            send_block(b, -1, BB);
            check($sformatf("t2_ok%0d", b), 32'(s_bok), 32'd1);
        end
        tail_check("t2", TC);
        check_stream("t2", 3 * BB);
        check("t2_ok_count", 32'(q_ok.size()), 32'd3);
        check("t2_err_crc", 32'(s_ecrc), 32'd0);

        // 4-bit, two blocks, lane 2 CRC bit flipped in block 0
        clear_mon();
        do_start(16'd2);
        send_block(0, 2, BB);
        check("t3_ok0", 32'(s_bok), 32'd0);
        check("t3_err_crc_set", 32'(s_ecrc), 32'd1);
        send_block(1, -1, BB);
        check("t3_ok1", 32'(s_bok), 32'd1);
        tail_check("t3", TC);
        check("t3_err_crc_done", 32'(s_ecrc), 32'd1);
        check_stream("t3", 2 * BB);

        // Timeout: DAT held high
        clear_mon();
        do_start(16'd1);
        check("t4_err_crc_cleared", 32'(s_ecrc), 32'd0);
        early = 0;
        for (int k = 0; k < TO; k++) begin
            strobe(4'hF);
            if (s_done) early++;
        end
        check("t4_done_early", 32'(early), 32'd0);
        check("t4_eto_early", 32'(s_eto), 32'd0);
        strobe(4'hF);
        check("t4_done", 32'(s_done), 32'd1);
        check("t4_eto", 32'(s_eto), 32'd1);
        check("t4_busy_low", 32'(s_busy), 32'd0);
        check("t4_no_bytes", 32'(q_byte.size()), 32'd0);
        do_start(16'd1);
        check("t4_eto_cleared", 32'(s_eto), 32'd0);
        check("t4_restart_busy", 32'(s_busy), 32'd1);
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        check("t4_abort_busy", 32'(s_busy), 32'd0);

        // Abort after byte 10 of block 0
        clear_mon();
        do_start(16'd1);
        send_block(0, -1, 10);
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        check("t5_busy_low", 32'(s_busy), 32'd0);
        for (int k = 0; k < 40; k++) strobe(4'h5);
        check("t5_bytes_stopped", 32'(q_byte.size()), 32'd10);
        check("t5_no_done", 32'(done_cnt), 32'd0);
        clear_mon();
        do_start(16'd1);
        send_block(0, -1, BB);
        tail_check("t5r", TC);
        check_stream("t5r", BB);

        // nblocks=0 acts as 1; start while busy is ignored
        clear_mon();
        do_start(16'd0);
        start4 = 1'b1; strobe(4'hF); start4 = 1'b0;
        send_block(0, -1, BB);
        start4 = 1'b1; strobe(4'hF); start4 = 1'b0;
        tail_check("t6", TC - 1);
        check("t6_blocks", 32'(q_ok.size()), 32'd1);
        check("t6_bytes", 32'(q_byte.size()), 32'(BB));
        check("t6_done_count", 32'(done_cnt), 32'd1);

        // abort and start together while idle: abort wins
        start4 = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; abort = 1'b0;
        check("t7_busy", 32'(s_busy), 32'd0);
        @(posedge clk); #1;
        check("t7_busy_later", 32'(s_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
